// File: rtl/fb_write_scheduler.sv
// rtl/fb_write_scheduler.sv - framebuffer write port arbiter between buffered CPU stores and a full-screen fill engine
module fb_write_scheduler #(
    parameter int RESOLUTION_X   = 400,
    parameter int RESOLUTION_Y   = 300,
    parameter int PALETTE_LENGTH = 256,
    parameter int FIFO_DEPTH     = 4,
    localparam int XW = $clog2(RESOLUTION_X),
    localparam int YW = $clog2(RESOLUTION_Y),
    localparam int PW = $clog2(PALETTE_LENGTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_cpu_wr_en,
    input  logic [XW-1:0] i_cpu_pxl_x,
    input  logic [YW-1:0] i_cpu_pxl_y,
    input  logic [PW-1:0] i_cpu_pxl_value,
    output logic          o_cpu_stall,
    input  logic          i_fill_start,
    input  logic [PW-1:0] i_fill_value,
    output logic          o_fill_busy,
    output logic          o_fill_done,
    output logic          o_fb_wr_en,
    output logic [XW-1:0] o_fb_wr_pxl_x,
    output logic [YW-1:0] o_fb_wr_pxl_y,
    output logic [PW-1:0] o_fb_wr_pxl_value,
    input  logic          i_fb_wr_ready
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int EW = XW + YW + PW;

    localparam logic [XW-1:0] LAST_X = XW'(RESOLUTION_X - 1);
    localparam logic [YW-1:0] LAST_Y = YW'(RESOLUTION_Y - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2
    } fill_state_t;

    // Store buffer
    logic [EW-1:0] r_fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Fill engine
    fill_state_t   r_state;
    fill_state_t   w_next_state;
    logic [XW-1:0] r_fill_x;
    logic [YW-1:0] r_fill_y;
    logic [PW-1:0] r_fill_value;
    logic          r_fill_done;
    logic          w_fill_done_next;

    // Output slot and arbitration
    logic          r_fb_wr_en;
    logic [XW-1:0] r_fb_wr_pxl_x;
    logic [YW-1:0] r_fb_wr_pxl_y;
    logic [PW-1:0] r_fb_wr_pxl_value;
    logic          r_rr_cpu;

    logic          w_cpu_stall;
    logic          w_in_range;
    logic          w_push;
    logic          w_pop;
    logic          w_slot_free;
    logic          w_xfer;
    logic          w_cpu_pend;
    logic          w_fill_pend;
    logic          w_contended;
    logic          w_grant_cpu;
    logic          w_grant_fill;
    logic          w_fill_last;
    logic [EW-1:0] w_head;
    logic [XW-1:0] w_head_x;
    logic [YW-1:0] w_head_y;
    logic [PW-1:0] w_head_value;

    // Stall comes only from the registered occupancy so a pop never frees a slot in the same cycle.
    assign w_cpu_stall  = (r_count == FULL_COUNT);
    assign w_in_range   = (i_cpu_pxl_x <= LAST_X) && (i_cpu_pxl_y <= LAST_Y);
    // Out-of-range stores are acknowledged but silently dropped.
    assign w_push       = i_cpu_wr_en && !w_cpu_stall && w_in_range;

    assign w_slot_free  = !r_fb_wr_en || i_fb_wr_ready;
    assign w_xfer       = r_fb_wr_en && i_fb_wr_ready;
    assign w_cpu_pend   = (r_count != '0);
    assign w_fill_pend  = (r_state == S_FILL);
    assign w_contended  = w_cpu_pend && w_fill_pend;
    assign w_fill_last  = (r_fill_x == LAST_X) && (r_fill_y == LAST_Y);
    assign w_pop        = w_grant_cpu;

    assign w_head       = r_fifo_mem[r_rd_ptr];
    assign w_head_x     = w_head[EW-1 -: XW];
    assign w_head_y     = w_head[PW +: YW];
    assign w_head_value = w_head[PW-1:0];

    // Pick the source that loads the output slot; round-robin only when both want it.
    always_comb begin
        w_grant_cpu  = 1'b0;
        w_grant_fill = 1'b0;
        if (w_slot_free) begin
            if (w_contended) begin
                if (r_rr_cpu) begin
                    w_grant_cpu = 1'b1;
                end else begin
                    w_grant_fill = 1'b1;
                end
            end else if (w_cpu_pend) begin
                w_grant_cpu = 1'b1;
            end else if (w_fill_pend) begin
                w_grant_fill = 1'b1;
            end
        end
    end

    // Store buffer payload; contents need no reset because occupancy gates every read.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= {i_cpu_pxl_x, i_cpu_pxl_y, i_cpu_pxl_value};
        end
    end

    // Store buffer pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Round-robin pointer flips only after a contended grant.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_cpu <= 1'b1;
        end else if (w_slot_free && w_contended) begin
            r_rr_cpu <= !r_rr_cpu;
        end
    end

    // Fill FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_fill_done <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_fill_done <= w_fill_done_next;
        end
    end

    // Fill FSM next state: DRAIN waits for the final fill beat, which sits in the slot until it transfers.
    always_comb begin
        w_next_state     = r_state;
        w_fill_done_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_fill_start) begin
                    w_next_state = S_FILL;
                end
            end
            S_FILL: begin
                if (w_grant_fill && w_fill_last) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_xfer) begin
                    w_next_state     = S_IDLE;
                    w_fill_done_next = 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Fill sweep coordinates advance row-major each time a fill beat is loaded.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fill_x     <= '0;
            r_fill_y     <= '0;
            r_fill_value <= '0;
        end else if ((r_state == S_IDLE) && i_fill_start) begin
            r_fill_x     <= '0;
            r_fill_y     <= '0;
            r_fill_value <= i_fill_value;
        end else if (w_grant_fill && !w_fill_last) begin
            if (r_fill_x == LAST_X) begin
                r_fill_x <= '0;
                r_fill_y <= r_fill_y + YW'(1);
            end else begin
                r_fill_x <= r_fill_x + XW'(1);
            end
        end
    end

    // Output slot: load on grant, empty after transfer, hold while backpressured.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fb_wr_en        <= 1'b0;
            r_fb_wr_pxl_x     <= '0;
            r_fb_wr_pxl_y     <= '0;
            r_fb_wr_pxl_value <= '0;
        end else if (w_slot_free) begin
            r_fb_wr_en <= w_grant_cpu || w_grant_fill;
            if (w_grant_cpu) begin
                r_fb_wr_pxl_x     <= w_head_x;
                r_fb_wr_pxl_y     <= w_head_y;
                r_fb_wr_pxl_value <= w_head_value;
            end else if (w_grant_fill) begin
                r_fb_wr_pxl_x     <= r_fill_x;
                r_fb_wr_pxl_y     <= r_fill_y;
                r_fb_wr_pxl_value <= r_fill_value;
            end
        end
    end

    assign o_cpu_stall       = w_cpu_stall;
    assign o_fill_busy       = (r_state != S_IDLE);
    assign o_fill_done       = r_fill_done;
    assign o_fb_wr_en        = r_fb_wr_en;
    assign o_fb_wr_pxl_x     = r_fb_wr_pxl_x;
    assign o_fb_wr_pxl_y     = r_fb_wr_pxl_y;
    assign o_fb_wr_pxl_value = r_fb_wr_pxl_value;

endmodule

// File: doc/fb_write_scheduler.md
# fb_write_scheduler

Shares the single framebuffer write port between two requesters: the processor Memory stage (pixel stores) and a built-in hardware fill engine that clears or paints the whole screen to one palette index. Processor stores are buffered in a small FIFO so the pipeline stalls only when the FIFO is full. Fill beats and buffered stores are interleaved round-robin onto a registered output slot with a valid/ready handshake toward the framebuffer.

## Interface
- RESOLUTION_X, 400, pixels per row; XW = $clog2(RESOLUTION_X)
- RESOLUTION_Y, 300, rows; YW = $clog2(RESOLUTION_Y)
- PALETTE_LENGTH, 256, palette entries; PW = $clog2(PALETTE_LENGTH)
- FIFO_DEPTH, 4, processor store buffer entries (power of two, ≥2)
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately
- cpu_wr_en  in  1  processor pixel store request (Memory stage fb write)
- cpu_pxl_x  in  XW  store x
- cpu_pxl_y  in  YW  store y
- cpu_pxl_value  in  PW  store palette index
- cpu_stall  out  1  FIFO full; store not accepted this cycle
- fill_start  in  1  one-cycle command to begin a full-screen fill
- fill_value  in  PW  fill palette index, sampled with fill_start
- fill_busy  out  1  fill in progress
- fill_done  out  1  one-cycle pulse when the last fill pixel has transferred
- fb_wr_en  out  1  output slot valid
- fb_wr_pxl_x  out  XW  output x
- fb_wr_pxl_y  out  YW  output y
- fb_wr_pxl_value  out  PW  output value
- fb_wr_ready  in  1  framebuffer accepts the slot this cycle

## Operation
- Reset values: cpu_stall=0, fill_busy=0, fill_done=0, fb_wr_en=0, fb_wr_pxl_x/y/value=0; FIFO empty; RR pointer favours CPU; fill FSM IDLE.
- Store acceptance: accepted when cpu_wr_en && !cpu_stall. cpu_stall = (count == FIFO_DEPTH), from registered count only; no same-cycle pop pass-through.
- Out-of-range stores (x ≥ RESOLUTION_X or y ≥ RESOLUTION_Y) are accepted (consume no stall) and discarded; never enqueued.
- Fill FSM: IDLE --fill_start--> FILL (latch fill_value, x=0, y=0) --last beat loaded--> DRAIN --last beat transferred--> IDLE with fill_done pulse. fill_start outside IDLE is ignored.
- Fill sweep is row-major: x increments per loaded beat; at x=RESOLUTION_X-1 wrap to 0 and increment y; last beat is (RESOLUTION_X-1, RESOLUTION_Y-1).
- Output slot: "free" when fb_wr_en=0 or (fb_wr_en && fb_wr_ready). Slot contents held stable while fb_wr_en && !fb_wr_ready.
- Arbitration on a free slot: only one source pending -> grant it; both pending (FIFO non-empty and FSM in FILL) -> grant per RR pointer, then pointer flips to the other source. Pointer changes only on contended grants.
- No pixel-level ordering between sources: a store to a pixel not yet swept is overwritten by the fill. Software waits for fill_done before dependent stores.
- fill_busy = FSM not IDLE.

## Timing
- Store accepted in cycle N -> fb_wr_en earliest in cycle N+2 (FIFO at edge N, slot load at edge N+1).
- fill_start in cycle N -> fill_busy high N+1, pixel (0,0) on output N+2 earliest.
- Throughput: one transfer per cycle with fb_wr_ready held high; single source uncontended gets every cycle.
- Fill of 400x300 with ready high and no stores: 120000 transfers in consecutive cycles; fill_done pulses the cycle after the last transfer; fill_busy falls that same cycle.
- Simultaneous push and pop: count unchanged; when full, push blocked regardless of pop.
- Reset mid-fill or mid-stall: all state cleared asynchronously; pending FIFO entries and slot lost; no fill_done.

## Test plan
- Reset: hold reset=0 with random inputs -> all outputs 0; release, single store (5,7,0x21) with ready=1 -> fb_wr_en high exactly 2 cycles later with (5,7,0x21), one cycle only.
- Backpressure: ready=0, issue 5 stores on consecutive cycles -> first 4 (+slot fill) accepted, cpu_stall=1 while count=4; raise ready -> all stores emerge in order, none duplicated or lost.
- Out-of-range: store (400,0) and (0,300) -> cpu_stall stays 0, no fb_wr_en.
- Full fill 400x300 value 0x00, ready=1 -> 120000 beats row-major, last (399,299), fill_done single pulse the following cycle; second fill_start during fill ignored.
- Contention: during fill, 3 stores back-to-back -> output alternates CPU/fill beats, fill sweep has no skipped or repeated coordinate.
- Reset mid-fill at beat 1000 -> fill_busy=0 immediately, no fill_done; new fill_start restarts at (0,0).
